// File: rtl/brc_seq_if.sv
// Request/result handshake bundle for the multi-cycle branch comparator.
// The slave modport is the comparator side and the master modport is the EX stage side.
interface brc_seq_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_rs1_data;
  logic [WIDTH-1:0] i_rs2_data;
  logic [2:0]       i_br_op;
  logic             i_flush;
  logic             o_valid;
  logic             i_ready;
  logic             o_br_less;
  logic             o_br_equal;
  logic             o_taken;
  logic             o_illegal;

  modport slave (
    input  i_valid, i_rs1_data, i_rs2_data, i_br_op, i_flush, i_ready,
    output o_ready, o_valid, o_br_less, o_br_equal, o_taken, o_illegal
  );

  modport master (
    output i_valid, i_rs1_data, i_rs2_data, i_br_op, i_flush, i_ready,
    input  o_ready, o_valid, o_br_less, o_br_equal, o_taken, o_illegal
  );
endinterface

// File: rtl/brc_seq.sv
// Multi-cycle branch comparator: walks the operands one CHUNK-bit slice per cycle,
// most significant slice first, and decodes the RISC-V branch funct3 into a taken flag.
module brc_seq #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  brc_seq_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             less_q;
  logic             eq_q;
  logic             found_q;
  logic             ready_q;
  logic             valid_q;
  logic             br_less_q;
  logic             br_equal_q;
  logic             taken_q;
  logic             illegal_q;

  logic [CHUNK-1:0] a_sl_s;
  logic [CHUNK-1:0] b_sl_s;
  logic             less_d;
  logic             eq_d;
  logic             found_d;
  logic             fin_d;

  function automatic logic taken_f(input logic [2:0] op, input logic less, input logic eq);
    logic t;
    case (op)
      3'b000:         t = eq;
      3'b001:         t = !eq;
      3'b100, 3'b110: t = less;
      3'b101, 3'b111: t = !less;
      default:        t = 1'b0;
    endcase
    return t;
  endfunction

  // Slice compare; with EARLY_EXIT=0 only the first difference seen is kept.
  always_comb begin
    a_sl_s  = a_q[int'(idx_q)*CHUNK +: CHUNK];
    b_sl_s  = b_q[int'(idx_q)*CHUNK +: CHUNK];
    less_d  = less_q;
    eq_d    = eq_q;
    found_d = found_q;
    if (!found_q && (a_sl_s > b_sl_s)) begin
      less_d  = 1'b0;
      eq_d    = 1'b0;
      found_d = 1'b1;
    end else if (!found_q && (a_sl_s < b_sl_s)) begin
      less_d  = 1'b1;
      eq_d    = 1'b0;
      found_d = 1'b1;
    end else if (!found_q && (idx_q == {IW{1'b0}})) begin
      less_d  = 1'b0;
      eq_d    = 1'b1;
    end else begin
      found_d = found_q;
    end
    if (idx_q == {IW{1'b0}}) begin
      fin_d = 1'b1;
    end else if (EARLY_EXIT != 0) begin
      fin_d = (a_sl_s != b_sl_s);
    end else begin
      fin_d = 1'b0;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      idx_q      <= IDX_TOP;
      a_q        <= {WIDTH{1'b0}};
      b_q        <= {WIDTH{1'b0}};
      op_q       <= 3'b000;
      less_q     <= 1'b0;
      eq_q       <= 1'b0;
      found_q    <= 1'b0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      br_less_q  <= 1'b0;
      br_equal_q <= 1'b0;
      taken_q    <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (bus.i_flush) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      found_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid && ready_q) begin
            // Flipping the sign bit maps two's complement order onto unsigned order.
            a_q     <= bus.i_rs1_data ^ {!bus.i_br_op[1], {(WIDTH-1){1'b0}}};
            b_q     <= bus.i_rs2_data ^ {!bus.i_br_op[1], {(WIDTH-1){1'b0}}};
            op_q    <= bus.i_br_op;
            idx_q   <= IDX_TOP;
            found_q <= 1'b0;
            ready_q <= 1'b0;
            state_q <= BUSY;
          end else begin
            ready_q <= 1'b1;
          end
        end
        BUSY: begin
          less_q  <= less_d;
          eq_q    <= eq_d;
          found_q <= found_d;
          if (fin_d) begin
            state_q    <= DONE;
            valid_q    <= 1'b1;
            br_less_q  <= less_d;
            br_equal_q <= eq_d;
            taken_q    <= taken_f(op_q, less_d, eq_d);
            illegal_q  <= (op_q[2:1] == 2'b01);
          end else begin
            idx_q <= idx_q - IW'(1);
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_br_less  = br_less_q;
  assign bus.o_br_equal = br_equal_q;
  assign bus.o_taken    = taken_q;
  assign bus.o_illegal  = illegal_q;
endmodule
